// File: rtl/multi_dir_tlc_if.sv
// Signal bundle between the intersection sequencer and its environment.
// With EMERGENCY_PREEMPT_EN defined the bundle also carries emg/emg_dir.
interface multi_dir_tlc_if #(
  parameter int N_DIR = 2
) ();
  localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  logic [N_DIR-1:0]   req;
  logic [3*N_DIR-1:0] lights;
  logic [DIR_W-1:0]   active_dir;
  logic [1:0]         phase;
`ifdef EMERGENCY_PREEMPT_EN
  logic               emg;
  logic [DIR_W-1:0]   emg_dir;

  modport master (output req, output emg, output emg_dir,
                  input lights, input active_dir, input phase);
  modport slave  (input req, input emg, input emg_dir,
                  output lights, output active_dir, output phase);
`else
  modport master (output req, input lights, input active_dir, input phase);
  modport slave  (input req, output lights, output active_dir, output phase);
`endif
endinterface

// File: rtl/multi_dir_tlc.sv
// N-direction actuated traffic-light sequencer: latched requests served round-robin through
// GREEN -> YELLOW -> ALL_RED. Optional emergency preemption is enabled by EMERGENCY_PREEMPT_EN.
module multi_dir_tlc #(
  parameter int N_DIR     = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1
) (
  input  logic           clk,
  input  logic           rst,
  multi_dir_tlc_if.slave bus
);
  localparam int DIR_W = $clog2(N_DIR);

  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(N_DIR - 1);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N_DIR-1:0] pending_q, pending_d;
  logic [DIR_W-1:0] cur_q, cur_d;

  logic [N_DIR-1:0] cur_onehot;
  logic [N_DIR-1:0] green_mask;
  logic [DIR_W-1:0] rr_dir;
  logic [DIR_W-1:0] serve_dir;
  logic             other_pending;
  logic             req_cur;
  logic             min_done;
  logic             max_done;
  logic             green_exit;
  logic             leave_green;

  function automatic logic [DIR_W-1:0] rr_idx(input logic [DIR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_DIR) s = s - N_DIR;
    return DIR_W'(s);
  endfunction

  for (genvar gi = 0; gi < N_DIR; gi++) begin : g_onehot
    assign cur_onehot[gi] = (cur_q == DIR_W'(gi));
  end

  assign green_mask = (state_q == ST_GREEN) ? cur_onehot : '0;

  // Scan from the farthest candidate back to cur+1 so the nearest pending one wins;
  // with nothing pending the default simply advances to cur+1.
  always_comb begin
    rr_dir = rr_idx(cur_q, 1);
    for (int k = N_DIR; k >= 1; k--) begin
      if (pending_q[rr_idx(cur_q, k)]) rr_dir = rr_idx(cur_q, k);
    end
  end

  assign other_pending = |(pending_q & ~cur_onehot);
  assign req_cur       = |(bus.req & cur_onehot);
  assign min_done      = (timer_q >= GMIN_LAST);
  assign max_done      = (timer_q == GMAX_LAST);
  assign green_exit    = min_done && other_pending && (!req_cur || max_done);

`ifdef EMERGENCY_PREEMPT_EN
  logic emg_valid;
  logic emg_on_cur;

  assign emg_valid   = bus.emg && (int'(bus.emg_dir) < N_DIR);
  assign emg_on_cur  = emg_valid && (bus.emg_dir == cur_q);
  assign serve_dir   = emg_valid ? bus.emg_dir : rr_dir;
  assign leave_green = emg_valid ? !emg_on_cur : green_exit;
`else
  assign serve_dir   = rr_dir;
  assign leave_green = green_exit;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    cur_d     = cur_q;
    pending_d = pending_q | (bus.req & ~green_mask);
    case (state_q)
      ST_ALL_RED: begin
        if (timer_q == AR_LAST) begin
          state_d              = ST_GREEN;
          timer_d              = '0;
          cur_d                = serve_dir;
          pending_d[serve_dir] = 1'b0;
        end
      end
      ST_GREEN: begin
        // Saturating here lets an uncontested green hold forever.
        if (max_done) timer_d = timer_q;
        if (leave_green) begin
          state_d = ST_YELLOW;
          timer_d = '0;
        end
      end
      ST_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = ST_ALL_RED;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ALL_RED;
      timer_q   <= '0;
      pending_q <= '0;
      cur_q     <= LAST_DIR;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
    end
  end

  for (genvar gi = 0; gi < N_DIR; gi++) begin : g_lamp
    logic [2:0] lamp;
    assign lamp = !cur_onehot[gi]         ? 3'b100 :
                  (state_q == ST_GREEN)   ? 3'b001 :
                  (state_q == ST_YELLOW)  ? 3'b010 : 3'b100;
    assign bus.lights[3*gi +: 3] = lamp;
  end

  assign bus.phase      = state_q;
  assign bus.active_dir = cur_q;
endmodule

// File: tb/tb_multi_dir_tlc.sv
// Vector-table bench for multi_dir_tlc: a 2-direction and a 4-direction instance share one clock;
// each row's expected outputs go through a scoreboard queue and are checked after the edge.
module tb_multi_dir_tlc;
  logic clk;
  logic rst2;
  logic rst4;

  multi_dir_tlc_if #(.N_DIR(2)) bus2 ();
  multi_dir_tlc_if #(.N_DIR(4)) bus4 ();

  multi_dir_tlc #(
    .N_DIR(2), .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALL_RED_T(1)
  ) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  multi_dir_tlc #(
    .N_DIR(4), .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALL_RED_T(1)
  ) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          sel;
    logic        rst;
    logic [3:0]  req;
    logic        emg;
    logic        emg_dir;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic [1:0]  dir;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int total;
  int bad;

  // 2-direction light patterns {dir1, dir0}
  localparam logic [11:0] AR2 = 12'b000000_100100;
  localparam logic [11:0] G0  = 12'b000000_100001;
  localparam logic [11:0] Y0  = 12'b000000_100010;
  localparam logic [11:0] G1  = 12'b000000_001100;
  localparam logic [11:0] Y1  = 12'b000000_010100;
  // 4-direction light patterns {dir3, dir2, dir1, dir0}
  localparam logic [11:0] AR4  = 12'b100_100_100_100;
  localparam logic [11:0] G0_4 = 12'b100_100_100_001;
  localparam logic [11:0] Y0_4 = 12'b100_100_100_010;
  localparam logic [11:0] G1_4 = 12'b100_100_001_100;
  localparam logic [11:0] Y1_4 = 12'b100_100_010_100;
  localparam logic [11:0] G3_4 = 12'b001_100_100_100;

  task automatic add(input int sel, input logic r, input logic [3:0] rq, input logic e,
                     input logic ed, input logic [11:0] l, input logic [1:0] ph,
                     input logic [1:0] d);
    vec_t v;
    v.sel = sel; v.rst = r; v.req = rq; v.emg = e; v.emg_dir = ed;
    v.lights = l; v.phase = ph; v.dir = d;
    vecs.push_back(v);
  endtask

  task automatic check_row(input int idx);
    vec_t        e;
    logic [11:0] act_l;
    logic [1:0]  act_ph;
    logic [1:0]  act_d;
    int          non_red;
    e = exp_q.pop_front();
    if (e.sel == 0) begin
      act_l  = {6'b0, bus2.lights};
      act_ph = bus2.phase;
      act_d  = {1'b0, bus2.active_dir};
    end else begin
      act_l  = bus4.lights;
      act_ph = bus4.phase;
      act_d  = bus4.active_dir;
    end
    $display("row %0d dut%0d req=%b lights=%b phase=%b dir=%0d",
             idx, e.sel, e.req, act_l, act_ph, act_d);
    total++;
    if ({act_l, act_ph, act_d} !== {e.lights, e.phase, e.dir}) begin
      bad++;
      $display("FAIL outputs row %0d: got lights=%b phase=%b dir=%0d, need lights=%b phase=%b dir=%0d",
               idx, act_l, act_ph, act_d, e.lights, e.phase, e.dir);
    end
    non_red = 0;
    for (int f = 0; f < ((e.sel == 0) ? 2 : 4); f++) begin
      if (act_l[3*f +: 3] !== 3'b100) non_red++;
    end
    total++;
    if (non_red > 1) begin
      bad++;
      $display("FAIL conflict row %0d: got %0d non-red directions, need at most 1", idx, non_red);
    end
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    rst2  = 1'b1;
    rst4  = 1'b1;
    bus2.req = '0;
    bus4.req = '0;
`ifdef EMERGENCY_PREEMPT_EN
    bus2.emg = 1'b0; bus2.emg_dir = '0;
    bus4.emg = 1'b0; bus4.emg_dir = '0;
`endif

    // Reset, then uncontested dir0 green held
    add(0, 1, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 1, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    repeat (55) add(0, 0, 4'b00, 0, 0, G0, 2'b01, 2'd0);

    // Pulse req[1] at green entry: 3 green, 2 yellow, 1 all-red, dir1 green
    add(0, 1, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b10, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b00, 0, 0, Y0,  2'b10, 2'd0);
    add(0, 0, 4'b00, 0, 0, Y0,  2'b10, 2'd0);
    add(0, 0, 4'b00, 0, 0, AR2, 2'b00, 2'd0);
    add(0, 0, 4'b00, 0, 0, G1,  2'b01, 2'd1);
    repeat (8) add(0, 0, 4'b00, 0, 0, G1, 2'b01, 2'd1);
    // Hand back to dir0; dir0 must then hold (stale pending[1] would cut it short)
    add(0, 0, 4'b01, 0, 0, G1,  2'b01, 2'd1);
    add(0, 0, 4'b00, 0, 0, Y1,  2'b10, 2'd1);
    add(0, 0, 4'b00, 0, 0, Y1,  2'b10, 2'd1);
    add(0, 0, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    repeat (8) add(0, 0, 4'b00, 0, 0, G0, 2'b01, 2'd0);

    // req[0] held, req[1] pulsed: dir0 green exactly GREEN_MAX cycles
    add(0, 1, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b01, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b11, 0, 0, G0,  2'b01, 2'd0);
    repeat (4) add(0, 0, 4'b01, 0, 0, G0, 2'b01, 2'd0);
    add(0, 0, 4'b01, 0, 0, Y0,  2'b10, 2'd0);
    add(0, 0, 4'b01, 0, 0, Y0,  2'b10, 2'd0);
    add(0, 0, 4'b01, 0, 0, AR2, 2'b00, 2'd0);
    add(0, 0, 4'b00, 0, 0, G1,  2'b01, 2'd1);
    add(0, 0, 4'b00, 0, 0, G1,  2'b01, 2'd1);
    add(0, 0, 4'b00, 0, 0, G1,  2'b01, 2'd1);
    add(0, 0, 4'b00, 0, 0, Y1,  2'b10, 2'd1);
    add(0, 0, 4'b00, 0, 0, Y1,  2'b10, 2'd1);
    add(0, 0, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);

    // Reset mid-yellow with pending[1] set: pending dropped, dir0 green holds
    add(0, 0, 4'b10, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b00, 0, 0, Y0,  2'b10, 2'd0);
    add(0, 1, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    repeat (6) add(0, 0, 4'b00, 0, 0, G0, 2'b01, 2'd0);

    // Four directions: req[3] and req[1] together -> dir1 then dir3
    add(1, 1, 4'b0000, 0, 0, AR4,  2'b00, 2'd3);
    add(1, 1, 4'b0000, 0, 0, AR4,  2'b00, 2'd3);
    add(1, 0, 4'b0000, 0, 0, G0_4, 2'b01, 2'd0);
    add(1, 0, 4'b1010, 0, 0, G0_4, 2'b01, 2'd0);
    add(1, 0, 4'b0000, 0, 0, G0_4, 2'b01, 2'd0);
    add(1, 0, 4'b0000, 0, 0, Y0_4, 2'b10, 2'd0);
    add(1, 0, 4'b0000, 0, 0, Y0_4, 2'b10, 2'd0);
    add(1, 0, 4'b0000, 0, 0, AR4,  2'b00, 2'd0);
    add(1, 0, 4'b0000, 0, 0, G1_4, 2'b01, 2'd1);
    add(1, 0, 4'b0000, 0, 0, G1_4, 2'b01, 2'd1);
    add(1, 0, 4'b0000, 0, 0, G1_4, 2'b01, 2'd1);
    add(1, 0, 4'b0000, 0, 0, Y1_4, 2'b10, 2'd1);
    add(1, 0, 4'b0000, 0, 0, Y1_4, 2'b10, 2'd1);
    add(1, 0, 4'b0000, 0, 0, AR4,  2'b00, 2'd1);
    add(1, 0, 4'b0000, 0, 0, G3_4, 2'b01, 2'd3);
    repeat (5) add(1, 0, 4'b0000, 0, 0, G3_4, 2'b01, 2'd3);

`ifdef EMERGENCY_PREEMPT_EN
    // Emergency towards dir1 from a fresh dir0 green, then held against req[0]
    add(0, 1, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
    add(0, 0, 4'b00, 1, 1, Y0,  2'b10, 2'd0);
    add(0, 0, 4'b00, 1, 1, Y0,  2'b10, 2'd0);
    add(0, 0, 4'b00, 1, 1, AR2, 2'b00, 2'd0);
    add(0, 0, 4'b00, 1, 1, G1,  2'b01, 2'd1);
    repeat (25) add(0, 0, 4'b01, 1, 1, G1, 2'b01, 2'd1);
    add(0, 0, 4'b00, 0, 0, Y1,  2'b10, 2'd1);
    add(0, 0, 4'b00, 0, 0, Y1,  2'b10, 2'd1);
    add(0, 0, 4'b00, 0, 0, AR2, 2'b00, 2'd1);
    add(0, 0, 4'b00, 0, 0, G0,  2'b01, 2'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      if (v.sel == 0) begin
        rst2     = v.rst;
        bus2.req = v.req[1:0];
`ifdef EMERGENCY_PREEMPT_EN
        bus2.emg     = v.emg;
        bus2.emg_dir = v.emg_dir;
`endif
      end else begin
        rst4     = v.rst;
        bus4.req = v.req;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      check_row(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
